// File: rtl/lock_sequencer.sv
// lock_sequencer: combination-lock sequencer (entry, check, hold, timeout, lockout).
// Ports: lock_clk, lock_rst_n (async, active low), digit, digit_valid, clear, prog
//   in; complete[7:0], unlocked, lockout, progress[2:0], fail_count[2:0] out.
// Define LOCK_PROGRAM_EN to allow reprogramming the code from UNLOCKED via prog.
module lock_sequencer #(
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int unsigned ENTRY_TIMEOUT  = 2_000_000,
  parameter int unsigned UNLOCK_HOLD    = 5_000_000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 10_000_000
) (
  input  logic       lock_clk,
  input  logic       lock_rst_n,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       clear,
  input  logic       prog,
  output logic [7:0] complete,
  output logic       unlocked,
  output logic       lockout,
  output logic [2:0] progress,
  output logic [2:0] fail_count
);

  localparam int unsigned M1 =
    (ENTRY_TIMEOUT > UNLOCK_HOLD) ? ENTRY_TIMEOUT : UNLOCK_HOLD;
  localparam int unsigned MAXC =
    (M1 > LOCKOUT_CYCLES) ? M1 : LOCKOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  // One shared counter; only one timed state is active at a time.
  localparam logic [CW-1:0] TO_LAST = CW'(ENTRY_TIMEOUT - 1);
  localparam logic [CW-1:0] HO_LAST = CW'(UNLOCK_HOLD - 1);
  localparam logic [CW-1:0] LO_LAST = CW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]    MF      = 3'(MAX_FAILS);

`ifdef LOCK_PROGRAM_EN
  typedef enum logic [2:0] {
    IDLE, ENTRY, CHECK, UNLOCKED, LOCKOUT, PROGRAM
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, ENTRY, CHECK, UNLOCKED, LOCKOUT
  } state_t;
`endif

  state_t        state, state_n;
  logic [15:0]   entry, entry_n;
  logic [2:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    fails, fails_n;
  logic [15:0]   code;
  logic          accept;
  logic [15:0]   shifted;

`ifdef LOCK_PROGRAM_EN
  logic [15:0] code_n;
`else
  logic prog_unused;
  assign prog_unused = prog;
  assign code = CODE;
`endif

  assign accept  = digit_valid && (digit <= 4'd9);
  // First digit ends up in [15:12] after four shifts.
  assign shifted = {entry[11:0], digit};

  always_ff @(posedge lock_clk or negedge lock_rst_n) begin
    if (!lock_rst_n) begin
      state <= IDLE;
      entry <= '0;
      idx   <= '0;
      cnt   <= '0;
      fails <= '0;
`ifdef LOCK_PROGRAM_EN
      code  <= CODE;
`endif
    end else begin
      state <= state_n;
      entry <= entry_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      fails <= fails_n;
`ifdef LOCK_PROGRAM_EN
      code  <= code_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    entry_n = entry;
    idx_n   = idx;
    cnt_n   = cnt;
    fails_n = fails;
`ifdef LOCK_PROGRAM_EN
    code_n  = code;
`endif
    unique case (state)
      IDLE: begin
        if (accept) begin
          entry_n = shifted;
          idx_n   = 3'd1;
          cnt_n   = '0;
          state_n = ENTRY;
        end
      end
      ENTRY: begin
        if (clear) begin
          idx_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (accept) begin
          entry_n = shifted;
          idx_n   = idx + 3'd1;
          cnt_n   = '0;
          if (idx == 3'd3) state_n = CHECK;
        end else if (cnt == TO_LAST) begin
          idx_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      CHECK: begin
        idx_n = '0;
        cnt_n = '0;
        if (entry == code) begin
          fails_n = '0;
          state_n = UNLOCKED;
        end else if ((fails + 3'd1) >= MF) begin
          fails_n = MF;
          state_n = LOCKOUT;
        end else begin
          fails_n = fails + 3'd1;
          state_n = IDLE;
        end
      end
      UNLOCKED: begin
        if (clear) begin
          cnt_n   = '0;
          state_n = IDLE;
`ifdef LOCK_PROGRAM_EN
        end else if (prog) begin
          idx_n   = '0;
          cnt_n   = '0;
          state_n = PROGRAM;
`endif
        end else if (cnt == HO_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      LOCKOUT: begin
        if (cnt == LO_LAST) begin
          cnt_n   = '0;
          fails_n = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`ifdef LOCK_PROGRAM_EN
      PROGRAM: begin
        if (clear) begin
          idx_n   = '0;
          state_n = IDLE;
        end else if (accept) begin
          entry_n = shifted;
          idx_n   = idx + 3'd1;
          if (idx == 3'd3) begin
            code_n  = shifted;
            idx_n   = '0;
            state_n = IDLE;
          end
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered one edge behind the state/counters.
  always_ff @(posedge lock_clk or negedge lock_rst_n) begin
    if (!lock_rst_n) begin
      complete   <= 8'h00;
      unlocked   <= 1'b0;
      lockout    <= 1'b0;
      progress   <= '0;
      fail_count <= '0;
    end else begin
      complete   <= (state == UNLOCKED) ? 8'hFF : 8'h00;
      unlocked   <= (state == UNLOCKED);
      lockout    <= (state == LOCKOUT);
      progress   <= idx;
      fail_count <= fails;
    end
  end

endmodule
